// File: rtl/memory_port_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : memory_port_arbiter_if
//  Purpose  : Bundles the two-requester command/response bus and the
//             MemoryManager CPU-side port used by memory_port_arbiter.
//  Ports    : (interface signals, port 1 in the upper half of packed fields)
//    cmdValid/cmdReady/cmdWrite [2]  command handshake per port
//    cmdX [18], cmdY [16], cmdWData [16]  command payload per port
//    rspDone [2], rspError, rspRData [8]  one-cycle response
//    memoryXCoord/YCoord/WriteData, memoryRead/WriteRequest  to MemoryManager
//    memoryReadData, memoryRead/WriteComplete  from MemoryManager
//    busy                             arbiter not idle
//  Modports : slave = arbiter side, master = requesters + MemoryManager side
//  Revision : 1.0  initial release
// ============================================================================
interface memory_port_arbiter_if;
  logic [1:0]  cmdValid;
  logic [1:0]  cmdReady;
  logic [1:0]  cmdWrite;
  logic [17:0] cmdX;
  logic [15:0] cmdY;
  logic [15:0] cmdWData;
  logic [1:0]  rspDone;
  logic        rspError;
  logic [7:0]  rspRData;
  logic [8:0]  memoryXCoord;
  logic [7:0]  memoryYCoord;
  logic [7:0]  memoryWriteData;
  logic        memoryReadRequest;
  logic        memoryWriteRequest;
  logic [7:0]  memoryReadData;
  logic        memoryReadComplete;
  logic        memoryWriteComplete;
  logic        busy;

  modport slave (
    input  cmdValid, cmdWrite, cmdX, cmdY, cmdWData,
    input  memoryReadData, memoryReadComplete, memoryWriteComplete,
    output cmdReady, rspDone, rspError, rspRData,
    output memoryXCoord, memoryYCoord, memoryWriteData,
    output memoryReadRequest, memoryWriteRequest, busy
  );

  modport master (
    output cmdValid, cmdWrite, cmdX, cmdY, cmdWData,
    output memoryReadData, memoryReadComplete, memoryWriteComplete,
    input  cmdReady, rspDone, rspError, rspRData,
    input  memoryXCoord, memoryYCoord, memoryWriteData,
    input  memoryReadRequest, memoryWriteRequest, busy
  );
endinterface
`default_nettype wire

// File: rtl/memory_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : memory_port_arbiter
//  Purpose  : Shares the MemoryManager CPU-side port between port 0 (host
//             bus) and port 1 (fill/blit engine). One command slot per port,
//             round-robin selection on ties, coordinate range check,
//             timeout on stalled accesses, one-cycle response per command.
//  Ports    :
//    clock  in   system clock, rising edge
//    reset  in   asynchronous, active-low
//    bus    slave modport of memory_port_arbiter_if (command, response and
//           MemoryManager signals)
//  Revision : 1.0  initial release
// ============================================================================
module memory_port_arbiter #(
  parameter int SCREEN_WIDTH   = 320,
  parameter int SCREEN_HEIGHT  = 240,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                         clock,
  input  logic                         reset,
  memory_port_arbiter_if.slave         bus
);

  localparam logic [8:0] c_x_limit = SCREEN_WIDTH[8:0];
  localparam logic [7:0] c_y_limit = SCREEN_HEIGHT[7:0];
  localparam logic [3:0] c_timeout = TIMEOUT_CYCLES[3:0];

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE_RD = 2'd1,
    ISSUE_WR = 2'd2,
    RESPOND  = 2'd3
  } state_t;

  state_t          state_q, state_d;

  // Command slots
  logic [1:0]      slot_full_q, slot_full_d;
  logic [1:0]      slot_write_q, slot_write_d;
  logic [1:0][8:0] slot_x_q, slot_x_d;
  logic [1:0][7:0] slot_y_q, slot_y_d;
  logic [1:0][7:0] slot_wdata_q, slot_wdata_d;

  // Arbitration / response state
  logic            owner_q, owner_d;
  logic            last_grant_q, last_grant_d;
  logic            err_q, err_d;
  logic [7:0]      rdata_q, rdata_d;

  // MemoryManager drive
  logic            rd_req_q, rd_req_d;
  logic            wr_req_q, wr_req_d;
  logic [8:0]      mem_x_q, mem_x_d;
  logic [7:0]      mem_y_q, mem_y_d;
  logic [7:0]      mem_wdata_q, mem_wdata_d;
  logic [3:0]      tmo_cnt_q, tmo_cnt_d;

  logic [1:0]      w_accept;
  logic            w_winner;
  logic            w_in_range;
  logic [3:0]      w_tmo_next;
  logic            w_timeout;

  assign w_accept   = bus.cmdValid & ~slot_full_q;
  // With exactly one slot full, slot_full_q[1] names it; on a tie the
  // port that did not win the previous tie goes first.
  assign w_winner   = (&slot_full_q) ? ~last_grant_q : slot_full_q[1];
  assign w_in_range = (slot_x_q[w_winner] < c_x_limit) &&
                      (slot_y_q[w_winner] < c_y_limit);
  assign w_tmo_next = tmo_cnt_q + 4'd1;
  assign w_timeout  = (w_tmo_next == c_timeout);

  // Slot capture and release
  always_comb begin
    slot_full_d  = slot_full_q | w_accept;
    slot_write_d = slot_write_q;
    slot_x_d     = slot_x_q;
    slot_y_d     = slot_y_q;
    slot_wdata_d = slot_wdata_q;
    for (int i = 0; i < 2; i++) begin
      if (w_accept[i]) begin
        slot_write_d[i] = bus.cmdWrite[i];
        slot_x_d[i]     = bus.cmdX[i*9 +: 9];
        slot_y_d[i]     = bus.cmdY[i*8 +: 8];
        slot_wdata_d[i] = bus.cmdWData[i*8 +: 8];
      end
    end
    // The owner's slot cannot be accepting in the same cycle (it is full),
    // so clearing here never races with a capture.
    if (state_q == RESPOND) begin
      slot_full_d[owner_q] = 1'b0;
    end
  end

  // FSM next-state and datapath
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    err_d        = err_q;
    rdata_d      = rdata_q;
    rd_req_d     = rd_req_q;
    wr_req_d     = wr_req_q;
    mem_x_d      = mem_x_q;
    mem_y_d      = mem_y_q;
    mem_wdata_d  = mem_wdata_q;
    tmo_cnt_d    = tmo_cnt_q;

    case (state_q)
      IDLE: begin
        if (|slot_full_q) begin
          owner_d = w_winner;
          if (&slot_full_q) begin
            last_grant_d = w_winner;
          end
          if (!w_in_range) begin
            err_d   = 1'b1;
            rdata_d = 8'h00;
            state_d = RESPOND;
          end else begin
            err_d       = 1'b0;
            mem_x_d     = slot_x_q[w_winner];
            mem_y_d     = slot_y_q[w_winner];
            mem_wdata_d = slot_wdata_q[w_winner];
            tmo_cnt_d   = 4'd0;
            if (slot_write_q[w_winner]) begin
              wr_req_d = 1'b1;
              state_d  = ISSUE_WR;
            end else begin
              rd_req_d = 1'b1;
              state_d  = ISSUE_RD;
            end
          end
        end
      end

      ISSUE_RD: begin
        // The request must fall on the same edge the completion is sampled,
        // otherwise the MemoryManager would see a second access.
        if (bus.memoryReadComplete) begin
          rdata_d  = bus.memoryReadData;
          rd_req_d = 1'b0;
          err_d    = 1'b0;
          state_d  = RESPOND;
        end else if (w_timeout) begin
          rdata_d  = 8'h00;
          rd_req_d = 1'b0;
          err_d    = 1'b1;
          state_d  = RESPOND;
        end else begin
          tmo_cnt_d = w_tmo_next;
        end
      end

      ISSUE_WR: begin
        if (bus.memoryWriteComplete) begin
          wr_req_d = 1'b0;
          err_d    = 1'b0;
          state_d  = RESPOND;
        end else if (w_timeout) begin
          rdata_d  = 8'h00;
          wr_req_d = 1'b0;
          err_d    = 1'b1;
          state_d  = RESPOND;
        end else begin
          tmo_cnt_d = w_tmo_next;
        end
      end

      RESPOND: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      slot_full_q  <= 2'b00;
      slot_write_q <= 2'b00;
      slot_x_q     <= '0;
      slot_y_q     <= '0;
      slot_wdata_q <= '0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      err_q        <= 1'b0;
      rdata_q      <= 8'h00;
      rd_req_q     <= 1'b0;
      wr_req_q     <= 1'b0;
      mem_x_q      <= 9'd0;
      mem_y_q      <= 8'd0;
      mem_wdata_q  <= 8'h00;
      tmo_cnt_q    <= 4'd0;
    end else begin
      state_q      <= state_d;
      slot_full_q  <= slot_full_d;
      slot_write_q <= slot_write_d;
      slot_x_q     <= slot_x_d;
      slot_y_q     <= slot_y_d;
      slot_wdata_q <= slot_wdata_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      err_q        <= err_d;
      rdata_q      <= rdata_d;
      rd_req_q     <= rd_req_d;
      wr_req_q     <= wr_req_d;
      mem_x_q      <= mem_x_d;
      mem_y_q      <= mem_y_d;
      mem_wdata_q  <= mem_wdata_d;
      tmo_cnt_q    <= tmo_cnt_d;
    end
  end

  assign bus.cmdReady           = ~slot_full_q;
  assign bus.rspDone            = (state_q == RESPOND) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign bus.rspError           = (state_q == RESPOND) && err_q;
  assign bus.rspRData           = rdata_q;
  assign bus.memoryXCoord       = mem_x_q;
  assign bus.memoryYCoord       = mem_y_q;
  assign bus.memoryWriteData    = mem_wdata_q;
  assign bus.memoryReadRequest  = rd_req_q;
  assign bus.memoryWriteRequest = wr_req_q;
  assign bus.busy               = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_memory_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_memory_port_arbiter
//  Purpose  : Self-checking bench for memory_port_arbiter with a
//             MemoryManager + RAM model and a per-port response scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module tb_memory_port_arbiter;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  memory_port_arbiter_if bus();

  memory_port_arbiter #(
    .SCREEN_WIDTH  (320),
    .SCREEN_HEIGHT (240),
    .TIMEOUT_CYCLES(15)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic       err;
    logic       chk;
    logic [7:0] rdata;
  } exp_t;

  exp_t sb0[$];
  exp_t sb1[$];
  int   served[$];
  int   errors = 0;
  int   checks = 0;

  logic [7:0] ram [0:131071];
  int   mem_lat  = 2;
  bit   mem_hang = 1'b0;
  bit   rd_seen  = 1'b0;
  bit   wr_seen  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // MemoryManager model: completes an access mem_lat cycles after the
  // request level is seen, unless mem_hang is set.
  initial begin
    int wait_cnt;
    wait_cnt = 0;
    forever begin
      @(posedge clock);
      #1;
      bus.memoryReadComplete  = 1'b0;
      bus.memoryWriteComplete = 1'b0;
      if (bus.memoryReadRequest || bus.memoryWriteRequest) begin
        wait_cnt++;
        if (!mem_hang && wait_cnt >= mem_lat) begin
          wait_cnt = 0;
          if (bus.memoryWriteRequest) begin
            ram[{bus.memoryYCoord, bus.memoryXCoord}] = bus.memoryWriteData;
            bus.memoryWriteComplete = 1'b1;
          end else begin
            bus.memoryReadData     = ram[{bus.memoryYCoord, bus.memoryXCoord}];
            bus.memoryReadComplete = 1'b1;
          end
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Monitor: protocol checks and scoreboard pop on every response.
  initial begin
    logic       prc, pwc, preq;
    logic [8:0] px;
    logic [7:0] py, pwd;
    exp_t       e;
    int         p;
    prc = 0; pwc = 0; preq = 0; px = 0; py = 0; pwd = 0;
    forever begin
      @(negedge clock);
      if (reset) begin
        if (bus.memoryReadRequest)  rd_seen = 1'b1;
        if (bus.memoryWriteRequest) wr_seen = 1'b1;
        if (bus.memoryReadRequest || bus.memoryWriteRequest)
          check("single_req_level", 32'(bus.memoryReadRequest & bus.memoryWriteRequest), 32'd0);
        if (prc) check("rd_req_drop", 32'(bus.memoryReadRequest), 32'd0);
        if (pwc) check("wr_req_drop", 32'(bus.memoryWriteRequest), 32'd0);
        if (preq && (bus.memoryReadRequest || bus.memoryWriteRequest))
          check("mem_bus_stable", {7'd0, bus.memoryXCoord, bus.memoryYCoord, bus.memoryWriteData},
                {7'd0, px, py, pwd});
      end
      if (bus.rspDone != 2'b00) begin
        check("rsp_onehot", 32'($countones(bus.rspDone)), 32'd1);
        p = bus.rspDone[1] ? 1 : 0;
        served.push_back(p);
        if ((p == 0 && sb0.size() == 0) || (p == 1 && sb1.size() == 0)) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: actual rspDone=%b required=00", bus.rspDone);
        end else begin
          e = (p == 1) ? sb1.pop_front() : sb0.pop_front();
          check($sformatf("rsp_error_p%0d", p), 32'(bus.rspError), 32'(e.err));
          if (e.chk) check($sformatf("rsp_rdata_p%0d", p), 32'(bus.rspRData), 32'(e.rdata));
        end
      end
      prc  = bus.memoryReadComplete;
      pwc  = bus.memoryWriteComplete;
      preq = bus.memoryReadRequest | bus.memoryWriteRequest;
      px   = bus.memoryXCoord;
      py   = bus.memoryYCoord;
      pwd  = bus.memoryWriteData;
    end
  end

  // Offer one command on port p; the expectation is queued on acceptance.
  task automatic offer(input int p, input bit wr, input int x, input int y,
                       input int d, input exp_t e);
    int budget;
    @(posedge clock);
    #1;
    bus.cmdWrite[p]          = wr;
    bus.cmdX[p*9 +: 9]       = x[8:0];
    bus.cmdY[p*8 +: 8]       = y[7:0];
    bus.cmdWData[p*8 +: 8]   = d[7:0];
    bus.cmdValid[p]          = 1'b1;
    budget = 0;
    do begin
      @(negedge clock);
      budget++;
    end while (!bus.cmdReady[p] && budget < 100);
    if (!bus.cmdReady[p]) begin
      checks++;
      errors++;
      $display("FAIL accept_port%0d: actual cmdReady=0 required=1 within 100 cycles", p);
      bus.cmdValid[p] = 1'b0;
    end else begin
      @(posedge clock);
      if (p == 1) sb1.push_back(e); else sb0.push_back(e);
      #1;
      bus.cmdValid[p] = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int budget;
    budget = 0;
    do begin
      @(negedge clock);
      budget++;
    end while ((sb0.size() != 0 || sb1.size() != 0 || bus.busy) && budget < 300);
    check("drain_done", 32'(sb0.size() + sb1.size()), 32'd0);
  endtask

  task automatic wait_level(input bit rd);
    int budget;
    budget = 0;
    while (((rd ? bus.memoryReadRequest : bus.memoryWriteRequest) == 1'b0) && budget < 20) begin
      @(negedge clock);
      budget++;
    end
  endtask

  initial begin
    int   n;
    logic [16:0] idx;
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
    n = 0; idx = 0;
  end

  initial begin
    int          n;
    logic [16:0] idx;
    for (int i = 0; i < 131072; i++) ram[i] = 8'h00;
    bus.cmdValid = 2'b00; bus.cmdWrite = 2'b00;
    bus.cmdX = '0; bus.cmdY = '0; bus.cmdWData = '0;
    bus.memoryReadData = 8'h00;
    bus.memoryReadComplete = 1'b0; bus.memoryWriteComplete = 1'b0;

    // Reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_cmdReady", 32'(bus.cmdReady), 32'd3);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_rspDone", 32'(bus.rspDone), 32'd0);
    check("rst_rspError", 32'(bus.rspError), 32'd0);
    check("rst_rspRData", 32'(bus.rspRData), 32'd0);
    check("rst_req", {30'd0, bus.memoryReadRequest, bus.memoryWriteRequest}, 32'd0);
    check("rst_memxy", {7'd0, bus.memoryXCoord, bus.memoryYCoord, bus.memoryWriteData}, 32'd0);
    @(posedge clock); #1 reset = 1'b1;

    // Port 0 write (5,3) = A5
    rd_seen = 0; wr_seen = 0;
    offer(0, 1'b1, 5, 3, 8'hA5, '{1'b0, 1'b0, 8'h00});
    wait_level(1'b0);
    check("wr_req_high", 32'(bus.memoryWriteRequest), 32'd1);
    check("wr_coords", {15'd0, bus.memoryXCoord, bus.memoryYCoord}, {15'd0, 9'd5, 8'd3});
    check("wr_data", 32'(bus.memoryWriteData), 32'hA5);
    wait_idle();
    idx = {8'd3, 9'd5};
    check("ram_5_3", 32'(ram[idx]), 32'hA5);
    check("t1_no_read", 32'(rd_seen), 32'd0);

    // Port 1 read (5,3)
    rd_seen = 0; wr_seen = 0;
    offer(1, 1'b0, 5, 3, 0, '{1'b0, 1'b1, 8'hA5});
    wait_idle();
    check("t2_read_seen", 32'(rd_seen), 32'd1);
    check("t2_no_write", 32'(wr_seen), 32'd0);

    // Both ports, simultaneous then continuous re-offers
    @(posedge clock); #1 reset = 1'b0;
    @(posedge clock); #1 reset = 1'b1;
    served.delete();
    fork
      for (int k = 0; k < 3; k++) offer(0, 1'b1, 10 + k, 20, 8'h10 + k, '{1'b0, 1'b0, 8'h00});
      for (int k = 0; k < 3; k++) offer(1, 1'b1, 30 + k, 20, 8'h20 + k, '{1'b0, 1'b0, 8'h00});
    join
    wait_idle();
    check("grant_count", 32'(served.size()), 32'd6);
    for (int k = 0; k < 6 && k < served.size(); k++)
      check($sformatf("grant_order_%0d", k), 32'(served[k]), 32'(k % 2));
    idx = {8'd20, 9'd12};
    check("ram_12_20", 32'(ram[idx]), 32'h12);
    idx = {8'd20, 9'd32};
    check("ram_32_20", 32'(ram[idx]), 32'h22);

    // Out-of-range coordinates
    rd_seen = 0; wr_seen = 0;
    offer(0, 1'b1, 320, 0, 8'h77, '{1'b1, 1'b0, 8'h00});
    wait_idle();
    offer(0, 1'b1, 0, 240, 8'h77, '{1'b1, 1'b0, 8'h00});
    wait_idle();
    check("oor_no_mem_req", {30'd0, rd_seen, wr_seen}, 32'd0);

    // Timeout on a read, with a known-good read before and after
    offer(0, 1'b0, 5, 3, 0, '{1'b0, 1'b1, 8'hA5});
    wait_idle();
    mem_hang = 1'b1;
    offer(1, 1'b0, 7, 7, 0, '{1'b1, 1'b1, 8'h00});
    wait_level(1'b1);
    n = 0;
    while (bus.memoryReadRequest && n < 40) begin
      n++;
      @(negedge clock);
    end
    check("timeout_req_cycles", 32'(n), 32'd15);
    wait_idle();
    mem_hang = 1'b0;
    offer(0, 1'b0, 5, 3, 0, '{1'b0, 1'b1, 8'hA5});
    wait_idle();

    // Reset during ISSUE_WR
    mem_hang = 1'b1;
    offer(0, 1'b1, 1, 1, 8'h11, '{1'b0, 1'b0, 8'h00});
    wait_level(1'b0);
    check("pre_rst_wr_req", 32'(bus.memoryWriteRequest), 32'd1);
    @(posedge clock);
    #3 reset = 1'b0;
    #1;
    check("async_rst_wr_req", 32'(bus.memoryWriteRequest), 32'd0);
    sb0.delete();
    @(posedge clock); #1 reset = 1'b1;
    mem_hang = 1'b0;
    @(negedge clock);
    check("post_rst_cmdReady", 32'(bus.cmdReady), 32'd3);
    check("post_rst_busy", 32'(bus.busy), 32'd0);
    repeat (8) @(negedge clock);
    idx = {8'd1, 9'd1};
    check("rst_lost_write", 32'(ram[idx]), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
